keccak_obytes_unpacker: RTL

- Downstream stage of the keccak core.
- Captures the 64-bit squeeze words that the core emits with no backpressure (o_obytes / o_obytes_valid / o_obytes_done) into an internal word FIFO.
- Re-emits them as a byte stream with a valid/ready handshake, truncated to the requested output length, and flags the final byte.
- Decouples the core's bursty squeeze output from a slower byte-wide consumer, such as a bus writer or comparator.

---
 rtl/keccak_obytes_unpacker.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/keccak_obytes_unpacker.sv
// keccak_obytes_unpacker
//
// Downstream stage of the keccak core. Squeeze words from the core arrive
// with no backpressure and are buffered in a small word FIFO. They are then
// re-emitted as a byte stream with a valid/ready handshake, cut to the
// requested length, with the final byte flagged.
//
// Build option: define KECCAK_OBUF_LE_EN to emit the bytes of each word
// little-endian (lane 0 = [7:0]). The default is big-endian (lane 0 = [63:56]),
// which matches the core's packing.
//
// Ports
//   i_clk, i_rstn         clock, asynchronous active-low reset
//   i_start               one-cycle pulse, starts a message, latches i_obytes_len
//   i_obytes_len[9:0]     message length in bytes
//   i_obytes[63:0]        squeeze word, first byte in [63:56]
//   i_obytes_valid        word valid this cycle (always accepted)
//   i_obytes_done         core finished squeezing
//   o_byte[7:0]           output byte
//   o_byte_valid          o_byte valid
//   i_byte_ready          consumer takes o_byte when valid && ready
//   o_byte_last           marks the final byte of the message
//   o_busy                message in progress
//   o_done                one-cycle pulse after the message completes
//   o_overflow            sticky, a word was dropped because the FIFO was full
//
// FSM
//   state    | meaning
//   ST_IDLE  | waiting for i_start, words ignored
//   ST_RUN   | accepting words and emitting bytes
//   ST_FLUSH | all words in, draining the FIFO

module keccak_obytes_unpacker #(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [9:0]  i_obytes_len,
  input  logic [63:0] i_obytes,
  input  logic        i_obytes_valid,
  input  logic        i_obytes_done,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_byte_last,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t r_state, w_state_nxt;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [9:0]    r_len, r_bcnt;
  logic [7:0]    r_wcnt;
  logic [2:0]    r_lane;
  logic          r_done_seen, r_overflow, r_done;

  logic [10:0]   w_len_p7;
  logic [7:0]    w_need;
  logic          w_active, w_empty, w_full, w_valid, w_xfer, w_last, w_pop;
  logic          w_want, w_wr, w_ovf, w_start_ok, w_all_written, w_done_any;
  logic          w_done_nxt;
  logic [5:0]    w_shamt;
  logic [63:0]   w_head_shift;

  // Number of words that carry message bytes: ceil(len/8).
  assign w_len_p7   = {1'b0, r_len} + 11'd7;
  assign w_need     = w_len_p7[10:3];

  assign w_active   = (r_state != ST_IDLE);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_valid    = w_active && !w_empty;
  assign w_xfer     = w_valid && i_byte_ready;
  assign w_last     = (r_bcnt == (r_len - 10'd1));
  assign w_pop      = w_xfer && ((r_lane == 3'd7) || w_last);

  // Words beyond the message length are dropped. A word that falls in the
  // message window still advances the word count when it is lost to a full
  // FIFO, so the message always terminates.
  assign w_want     = (r_state == ST_RUN) && i_obytes_valid && (r_wcnt < w_need);
  assign w_wr       = w_want && (!w_full || w_pop);
  assign w_ovf      = w_want && w_full && !w_pop;
  assign w_start_ok = (r_state == ST_IDLE) && i_start;

  assign w_all_written = ({1'b0, r_wcnt} + {8'd0, w_want}) >= {1'b0, w_need};
  assign w_done_any    = r_done_seen || i_obytes_done;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_obytes_len != 10'd0) w_state_nxt = ST_RUN;
          else                       w_done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_xfer && w_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_done_any && w_all_written) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // An empty FIFO here means the tail was lost to overflow; finish anyway.
        if ((w_xfer && w_last) || w_empty) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_lane      <= '0;
      r_done_seen <= 1'b0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_start_ok) begin
        r_len       <= i_obytes_len;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_bcnt      <= '0;
        r_wcnt      <= '0;
        r_lane      <= '0;
        r_done_seen <= 1'b0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_want) r_wcnt <= r_wcnt + 8'd1;
        if ((r_state == ST_RUN) && i_obytes_done) r_done_seen <= 1'b1;
        if (w_ovf) r_overflow <= 1'b1;
        if (w_wr)  r_wr_ptr   <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr   <= r_rd_ptr + 1'b1;
        if (w_xfer) begin
          r_bcnt <= r_bcnt + 10'd1;
          r_lane <= w_pop ? 3'd0 : r_lane + 3'd1;
        end
        r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      end
    end
  end

  // Storage needs no reset: reads are gated by the FIFO count.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_obytes;
  end

`ifdef KECCAK_OBUF_LE_EN
  assign w_shamt = {r_lane, 3'b000};
`else
  assign w_shamt = {~r_lane, 3'b000};
`endif

  assign w_head_shift = r_mem[r_rd_ptr] >> w_shamt;

  assign o_byte       = w_valid ? w_head_shift[7:0] : 8'h00;
  assign o_byte_valid = w_valid;
  assign o_byte_last  = w_valid && w_last;
  assign o_busy       = w_active;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;

endmodule
